answer_arbiter: RTL and testbench

Round controller for the two-player factorisation game. Accepts 12-bit answer submissions from 1P and 2P and grants the single shared answer checker to one player at a time. Sequences the check, attributes the 2-bit result to the granted player, and keeps score. Applies wrong-answer lockout and requests the next question. Sits between the player input decoders and the checker/LED path.

---
 rtl/answer_arbiter_if.sv | 35 +++
 rtl/answer_arbiter.sv | 138 +++++++++++++
 tb/tb_answer_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/answer_arbiter_if.sv
// Purpose : bundles the player submission, checker and scoreboard/LED signals of answer_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: none; players re-assert VLD until ACK. master = players/checker side, slave = arbiter.
// Signals : ANS_xP/VLD_xP/ACK_xP per player; CHK_IN/CHK_RESULT to the checker;
//           WIN, LED_RES, NEXT_Q, LOCK_xP, SCORE_xP, GAME_OVER to the display path.
interface answer_arbiter_if;
  logic [11:0] ANS_1P;
  logic        VLD_1P;
  logic [11:0] ANS_2P;
  logic        VLD_2P;
  logic [1:0]  CHK_RESULT;
  logic [11:0] CHK_IN;
  logic        ACK_1P;
  logic        ACK_2P;
  logic [1:0]  WIN;
  logic [1:0]  LED_RES;
  logic        NEXT_Q;
  logic        LOCK_1P;
  logic        LOCK_2P;
  logic [3:0]  SCORE_1P;
  logic [3:0]  SCORE_2P;
  logic        GAME_OVER;

  modport master (
    output ANS_1P, VLD_1P, ANS_2P, VLD_2P, CHK_RESULT,
    input  CHK_IN, ACK_1P, ACK_2P, WIN, LED_RES, NEXT_Q,
           LOCK_1P, LOCK_2P, SCORE_1P, SCORE_2P, GAME_OVER
  );

  modport slave (
    input  ANS_1P, VLD_1P, ANS_2P, VLD_2P, CHK_RESULT,
    output CHK_IN, ACK_1P, ACK_2P, WIN, LED_RES, NEXT_Q,
           LOCK_1P, LOCK_2P, SCORE_1P, SCORE_2P, GAME_OVER
  );
endinterface

// File: rtl/answer_arbiter.sv
// Purpose : round controller of the two-player factorisation game; grants the shared checker,
//           judges the verdict, keeps score, applies wrong-answer lockout and requests next question.
// Latency : ACK one cycle after grant; CHK_IN held CHK_LAT+1 cycles; verdict/score/NEXT_Q visible
//           two cycles after the result is sampled, then LED held SHOW_CYC cycles.
// Backpressure: requests are only sampled in S_WAIT; dropped requests get no ACK and must be re-asserted.
// Ports   : CLK, RST (sync, active high); bus (slave modport) carries submissions, checker
//           handshake and scoreboard outputs.
module answer_arbiter #(
  parameter int CHK_LAT   = 2,
  parameter int SHOW_CYC  = 16,
  parameter int WIN_SCORE = 5
) (
  input  logic             CLK,
  input  logic             RST,
  answer_arbiter_if.slave  bus
);

  localparam int            CW        = 8;
  localparam logic [CW-1:0] CHK_LAST  = CW'(CHK_LAT);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);
  localparam logic [3:0]    WIN_PTS   = 4'(WIN_SCORE);

  typedef enum logic [1:0] {S_WAIT, S_CHECK, S_JUDGE, S_SHOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          prio_2p;   // 1: a tie goes to 2P (1P was granted last)
  logic          owner_2p;  // owner of the answer currently in flight
  logic [1:0]    res;       // verdict sampled at the end of S_CHECK

  logic       elig_1p, elig_2p, grant_1p, grant_2p;
  logic       check_done, show_done;
  logic       verdict_ok, lock_1p_new, lock_2p_new, skip;
  logic [3:0] score_1p_inc, score_2p_inc;

  always_comb begin
    elig_1p = bus.VLD_1P && !bus.LOCK_1P && (bus.ANS_1P != 12'd0) && !bus.GAME_OVER;
    elig_2p = bus.VLD_2P && !bus.LOCK_2P && (bus.ANS_2P != 12'd0) && !bus.GAME_OVER;
    grant_1p = (state == S_WAIT) && elig_1p && (!elig_2p || !prio_2p);
    grant_2p = (state == S_WAIT) && elig_2p && (!elig_1p ||  prio_2p);

    check_done = (state == S_CHECK) && (cnt == CHK_LAST);
    show_done  = (state == S_SHOW)  && (cnt == SHOW_LAST);

    // Only 01 counts as correct; 00/10 are judged as wrong.
    verdict_ok   = (res == 2'b01);
    score_1p_inc = (bus.SCORE_1P == 4'hF) ? 4'hF : bus.SCORE_1P + 4'd1;
    score_2p_inc = (bus.SCORE_2P == 4'hF) ? 4'hF : bus.SCORE_2P + 4'd1;
    lock_1p_new  = bus.LOCK_1P || (!verdict_ok && !owner_2p);
    lock_2p_new  = bus.LOCK_2P || (!verdict_ok &&  owner_2p);
    skip         = lock_1p_new && lock_2p_new;

    state_nxt = state;
    unique case (state)
      S_WAIT:  if (grant_1p || grant_2p) state_nxt = S_CHECK;
      S_CHECK: if (check_done)           state_nxt = S_JUDGE;
      S_JUDGE:                           state_nxt = S_SHOW;
      S_SHOW:  if (show_done)            state_nxt = S_WAIT;
      default:                           state_nxt = S_WAIT;
    endcase
  end

  // State register plus per-state cycle counter (restarts on every state change).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_2p       <= 1'b0;
      owner_2p      <= 1'b0;
      res           <= 2'b00;
      bus.CHK_IN    <= 12'd0;
      bus.ACK_1P    <= 1'b0;
      bus.ACK_2P    <= 1'b0;
      bus.WIN       <= 2'b00;
      bus.LED_RES   <= 2'b00;
      bus.NEXT_Q    <= 1'b0;
      bus.LOCK_1P   <= 1'b0;
      bus.LOCK_2P   <= 1'b0;
      bus.SCORE_1P  <= 4'd0;
      bus.SCORE_2P  <= 4'd0;
      bus.GAME_OVER <= 1'b0;
    end else begin
      bus.ACK_1P <= grant_1p;
      bus.ACK_2P <= grant_2p;
      bus.NEXT_Q <= 1'b0;

      // CHK_IN doubles as the latched answer for the whole check.
      if (grant_1p || grant_2p) begin
        bus.CHK_IN <= grant_1p ? bus.ANS_1P : bus.ANS_2P;
        owner_2p   <= grant_2p;
        prio_2p    <= grant_1p;
      end

      if (check_done) begin
        res        <= bus.CHK_RESULT;
        bus.CHK_IN <= 12'd0;
      end

      // Judgement lands on the S_JUDGE -> S_SHOW edge, so the verdict is shown
      // for exactly the S_SHOW window and NEXT_Q follows S_JUDGE by one cycle.
      if (state == S_JUDGE) begin
        bus.WIN     <= owner_2p ? 2'b10 : 2'b01;
        bus.LED_RES <= verdict_ok ? 2'b01 : 2'b11;
        if (verdict_ok) begin
          bus.NEXT_Q  <= 1'b1;
          bus.LOCK_1P <= 1'b0;
          bus.LOCK_2P <= 1'b0;
          if (owner_2p) begin
            bus.SCORE_2P <= score_2p_inc;
            if (score_2p_inc >= WIN_PTS) bus.GAME_OVER <= 1'b1;
          end else begin
            bus.SCORE_1P <= score_1p_inc;
            if (score_1p_inc >= WIN_PTS) bus.GAME_OVER <= 1'b1;
          end
        end else if (skip) begin
          // Both players missed: skip the question.
          bus.NEXT_Q  <= 1'b1;
          bus.LOCK_1P <= 1'b0;
          bus.LOCK_2P <= 1'b0;
        end else begin
          bus.LOCK_1P <= lock_1p_new;
          bus.LOCK_2P <= lock_2p_new;
        end
      end

      if (show_done) bus.LED_RES <= 2'b00;
    end
  end

endmodule

// File: tb/tb_answer_arbiter.sv
module tb_answer_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model of the game state.
  int         m_score [2];
  bit         m_lock  [2];
  bit         m_go;
  int         m_last;      // 0 none yet, 1 = 1P granted last, 2 = 2P granted last
  logic [1:0] m_win;

  answer_arbiter_if bus();

  answer_arbiter #(.CHK_LAT(2), .SHOW_CYC(16), .WIN_SCORE(5)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_score[0] = 0; m_score[1] = 0;
    m_lock[0]  = 0; m_lock[1]  = 0;
    m_go = 0; m_last = 0; m_win = 2'b00;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.VLD_1P = 1'b0; bus.VLD_2P = 1'b0;
    step(); step();
    RST = 1'b0;
    model_reset();
  endtask

  // One submission attempt starting in S_WAIT, followed through to the next S_WAIT.
  task automatic play(input bit v1, input logic [11:0] a1, input bit v2, input logic [11:0] a2,
                      input logic [1:0] verdict, input string nm);
    bit e1, e2, ok, bad;
    int g, o;
    logic [11:0] ans;
    logic [1:0]  exp_led;
    bit          exp_nq;

    e1 = v1 && !m_lock[0] && a1 != 0 && !m_go;
    e2 = v2 && !m_lock[1] && a2 != 0 && !m_go;
    if (e1 && e2) g = (m_last == 1) ? 2 : 1;
    else if (e1)  g = 1;
    else if (e2)  g = 2;
    else          g = 0;

    bus.CHK_RESULT = verdict;
    bus.VLD_1P = v1; bus.ANS_1P = a1;
    bus.VLD_2P = v2; bus.ANS_2P = a2;
    step();
    bus.VLD_1P = 1'b0; bus.VLD_2P = 1'b0;

    checks++;
    if (bus.ACK_1P !== (g == 1) || bus.ACK_2P !== (g == 2)) begin
      errors++;
      $display("FAIL %s ack: got {%b,%b} expected {%b,%b}", nm, bus.ACK_2P, bus.ACK_1P, g == 2, g == 1);
    end

    if (g == 0) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (bus.ACK_1P !== 1'b0 || bus.ACK_2P !== 1'b0 || bus.CHK_IN !== 12'd0) bad = 1;
        step();
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s idle: got ack/chk activity expected none", nm);
      end
      checks++;
      if (bus.SCORE_1P !== 4'(m_score[0]) || bus.SCORE_2P !== 4'(m_score[1]) ||
          bus.GAME_OVER !== m_go || bus.WIN !== m_win) begin
        errors++;
        $display("FAIL %s frozen: got s1=%0d s2=%0d go=%b win=%b expected s1=%0d s2=%0d go=%b win=%b",
                 nm, bus.SCORE_1P, bus.SCORE_2P, bus.GAME_OVER, bus.WIN, m_score[0], m_score[1], m_go, m_win);
      end
      return;
    end

    ans = (g == 1) ? a1 : a2;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.CHK_IN !== ans) bad = 1;
      if (i > 0 && (bus.ACK_1P !== 1'b0 || bus.ACK_2P !== 1'b0)) bad = 1;
      bus.VLD_1P = 1'($urandom_range(0, 1));
      bus.VLD_2P = 1'($urandom_range(0, 1));
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s chk_in: expected %h for 3 cycles with single ACK", nm, ans);
    end
    bus.CHK_RESULT = 2'($urandom_range(0, 3));
    checks++;
    if (bus.CHK_IN !== 12'd0) begin
      errors++;
      $display("FAIL %s chk_in_clear: got %h expected 000", nm, bus.CHK_IN);
    end

    // Model judgement.
    o = g - 1;
    m_last = g;
    ok = (verdict == 2'b01);
    m_win = (g == 2) ? 2'b10 : 2'b01;
    exp_led = ok ? 2'b01 : 2'b11;
    exp_nq = 0;
    if (ok) begin
      if (m_score[o] < 15) m_score[o]++;
      if (m_score[o] >= 5) m_go = 1;
      m_lock[0] = 0; m_lock[1] = 0;
      exp_nq = 1;
    end else begin
      m_lock[o] = 1;
      if (m_lock[0] && m_lock[1]) begin
        m_lock[0] = 0; m_lock[1] = 0;
        exp_nq = 1;
      end
    end

    step();
    checks++;
    if (bus.NEXT_Q !== exp_nq || bus.SCORE_1P !== 4'(m_score[0]) || bus.SCORE_2P !== 4'(m_score[1]) ||
        bus.LOCK_1P !== m_lock[0] || bus.LOCK_2P !== m_lock[1] || bus.WIN !== m_win ||
        bus.LED_RES !== exp_led || bus.GAME_OVER !== m_go) begin
      errors++;
      $display("FAIL %s judge: got nq=%b s1=%0d s2=%0d l1=%b l2=%b win=%b led=%b go=%b expected nq=%b s1=%0d s2=%0d l1=%b l2=%b win=%b led=%b go=%b",
               nm, bus.NEXT_Q, bus.SCORE_1P, bus.SCORE_2P, bus.LOCK_1P, bus.LOCK_2P, bus.WIN, bus.LED_RES, bus.GAME_OVER,
               exp_nq, m_score[0], m_score[1], m_lock[0], m_lock[1], m_win, exp_led, m_go);
    end

    bad = 0;
    for (int i = 1; i < 16; i++) begin
      bus.VLD_1P = 1'($urandom_range(0, 1));
      bus.VLD_2P = 1'($urandom_range(0, 1));
      bus.ANS_1P = 12'($urandom_range(1, 4095));
      bus.ANS_2P = 12'($urandom_range(1, 4095));
      step();
      if (bus.LED_RES !== exp_led || bus.NEXT_Q !== 1'b0 || bus.ACK_1P !== 1'b0 || bus.ACK_2P !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s show: expected led=%b for 16 cycles with no ACK/NEXT_Q", nm, exp_led);
    end
    step();
    bus.VLD_1P = 1'b0; bus.VLD_2P = 1'b0;
    checks++;
    if (bus.LED_RES !== 2'b00 || bus.WIN !== m_win) begin
      errors++;
      $display("FAIL %s led_clear: got led=%b win=%b expected led=00 win=%b", nm, bus.LED_RES, bus.WIN, m_win);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    checks++;
    if (bus.CHK_IN !== 12'd0 || bus.ACK_1P !== 1'b0 || bus.ACK_2P !== 1'b0 || bus.WIN !== 2'b00 ||
        bus.LED_RES !== 2'b00 || bus.NEXT_Q !== 1'b0 || bus.LOCK_1P !== 1'b0 || bus.LOCK_2P !== 1'b0 ||
        bus.SCORE_1P !== 4'd0 || bus.SCORE_2P !== 4'd0 || bus.GAME_OVER !== 1'b0) begin
      errors++;
      $display("FAIL reset: outputs not all zero (chk=%h win=%b led=%b s1=%0d s2=%0d go=%b)",
               bus.CHK_IN, bus.WIN, bus.LED_RES, bus.SCORE_1P, bus.SCORE_2P, bus.GAME_OVER);
    end
    RST = 1'b0;
    model_reset();
    step();
    checks++;
    if (bus.NEXT_Q !== 1'b0) begin
      errors++;
      $display("FAIL reset_nextq: got %b expected 0", bus.NEXT_Q);
    end
  endtask

  task automatic test_tie();
    play(1, 12'h111, 1, 12'h222, 2'b01, "tie_first");
    play(1, 12'h111, 1, 12'h222, 2'b01, "tie_second");
  endtask

  task automatic test_correct_1p();
    play(1, 12'h0C3, 0, 12'h000, 2'b01, "correct_1p");
  endtask

  task automatic test_lockout();
    play(1, 12'h0A5, 0, 12'h000, 2'b11, "lock_1p_wrong");
    play(1, 12'h0A6, 0, 12'h000, 2'b01, "lock_1p_retry");
    play(1, 12'h0A7, 1, 12'h0B1, 2'b01, "lock_2p_correct");
  endtask

  task automatic test_skip();
    play(1, 12'h0D1, 0, 12'h000, 2'b11, "skip_1p_wrong");
    play(0, 12'h000, 1, 12'h0D2, 2'b10, "skip_2p_wrong");
  endtask

  task automatic test_zero_answer();
    play(0, 12'h000, 1, 12'h000, 2'b01, "zero_ans_2p");
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    bus.CHK_RESULT = 2'b01;
    bus.VLD_1P = 1'b1; bus.ANS_1P = 12'h155;
    step();
    bus.VLD_1P = 1'b0;
    checks++;
    if (bus.ACK_1P !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ack: got %b expected 1", bus.ACK_1P);
    end
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    model_reset();
    checks++;
    if (bus.CHK_IN !== 12'd0 || bus.SCORE_1P !== 4'd0 || bus.LED_RES !== 2'b00 || bus.ACK_1P !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got chk=%h s1=%0d led=%b expected 000/0/00", bus.CHK_IN, bus.SCORE_1P, bus.LED_RES);
    end
    play(0, 12'h000, 1, 12'h0AA, 2'b01, "post_rst_grant");
  endtask

  task automatic test_game_over();
    do_reset();
    for (int i = 0; i < 5; i++)
      play(1, 12'($urandom_range(1, 4095)), 0, 12'h000, 2'b01, "win_run");
    checks++;
    if (bus.GAME_OVER !== 1'b1 || bus.SCORE_1P !== 4'd5) begin
      errors++;
      $display("FAIL game_over: got go=%b s1=%0d expected go=1 s1=5", bus.GAME_OVER, bus.SCORE_1P);
    end
    play(1, 12'h123, 1, 12'h456, 2'b01, "after_game_over");
    do_reset();
    checks++;
    if (bus.GAME_OVER !== 1'b0 || bus.SCORE_1P !== 4'd0 || bus.SCORE_2P !== 4'd0) begin
      errors++;
      $display("FAIL game_over_rst: got go=%b s1=%0d s2=%0d expected 0/0/0", bus.GAME_OVER, bus.SCORE_1P, bus.SCORE_2P);
    end
  endtask

  task automatic test_random();
    logic [1:0]  vd;
    logic [11:0] a1, a2;
    int r;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if (m_go) do_reset();
      a1 = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      a2 = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      r = $urandom_range(0, 7);
      if (r < 4)       vd = 2'b01;
      else if (r < 7)  vd = 2'b11;
      else             vd = $urandom_range(0, 1) ? 2'b10 : 2'b00;
      play(1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), a2, vd, "random");
    end
  endtask

  initial begin
    bus.ANS_1P = 12'd0; bus.VLD_1P = 1'b0;
    bus.ANS_2P = 12'd0; bus.VLD_2P = 1'b0;
    bus.CHK_RESULT = 2'b00;
    model_reset();
    test_reset();
    test_tie();
    test_correct_1p();
    test_lockout();
    test_skip();
    test_zero_answer();
    test_reset_mid_check();
    test_game_over();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
